// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cacheline memory arbiter.
// State encoding, requester identity and line geometry.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT_A,
        GRANT_B,
        DONE_A,
        DONE_B,
        TURN
    } arb_state_t;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_id_t;

    localparam int DEF_LINE_W = 256;
    localparam int LINE_BYTES = DEF_LINE_W / 8;

endpackage

// File: rtl/cacheline_mem_arbiter.sv
// Shares one cacheline pmem port between I-cache (A) and D-cache (B) misses:
// one transaction per grant, round-robin on conflict, sticky watchdog timeout flag.
module cacheline_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 256,
    parameter int OFFSET_W  = $clog2(LINE_BYTES),
    parameter int TIMEOUT_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_a,
    input  logic [ADDR_W-1:0] address_a,
    output logic [LINE_W-1:0] rdata_a,
    output logic              resp_a,
    input  logic              read_b,
    input  logic              write_b,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [LINE_W-1:0] wdata_b,
    output logic [LINE_W-1:0] rdata_b,
    output logic              resp_b,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              err_timeout
);

    localparam logic [ADDR_W-1:0]    LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};
    localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] WDOG_MAX  = {TIMEOUT_W{1'b1}};

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    req_id_t               r_last_grant;
    logic                  r_op_write;
    logic [ADDR_W-1:0]     r_addr;
    logic [LINE_W-1:0]     r_wdata;
    logic [LINE_W-1:0]     r_rdata_a;
    logic [LINE_W-1:0]     r_rdata_b;
    logic [TIMEOUT_W-1:0]  r_wdog;
    logic                  r_err;

    logic                  w_req_a;
    logic                  w_req_b;
    logic                  w_grant_a;
    logic                  w_grant_b;
    logic                  w_in_grant;
    logic [TIMEOUT_W-1:0]  w_wdog_inc;

    assign w_req_a    = read_a;
    assign w_req_b    = read_b | write_b;
    assign w_in_grant = (r_state == GRANT_A) || (r_state == GRANT_B);
    assign w_wdog_inc = r_wdog + WDOG_ONE;

    // On conflict the requester that did not win last time is served.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (r_state == IDLE) begin
            if (w_req_a && w_req_b) begin
                w_grant_a = (r_last_grant == REQ_B);
                w_grant_b = (r_last_grant == REQ_A);
            end else begin
                w_grant_a = w_req_a;
                w_grant_b = w_req_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_a) begin
                    w_state_nxt = GRANT_A;
                end else if (w_grant_b) begin
                    w_state_nxt = GRANT_B;
                end
            end
            GRANT_A: if (pmem_resp) w_state_nxt = DONE_A;
            GRANT_B: if (pmem_resp) w_state_nxt = DONE_B;
            DONE_A:  w_state_nxt = TURN;
            DONE_B:  w_state_nxt = TURN;
            TURN:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        resp_a     = 1'b0;
        resp_b     = 1'b0;
        case (r_state)
            GRANT_A: pmem_read = 1'b1;
            GRANT_B: begin
                pmem_write = r_op_write;
                pmem_read  = ~r_op_write;
            end
            DONE_A:  resp_a = 1'b1;
            DONE_B:  resp_b = 1'b1;
            default: ;
        endcase
    end

    // Request is captured once at grant; later requester input churn is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_op_write   <= 1'b0;
            r_last_grant <= REQ_B;
        end else if (w_grant_a) begin
            r_addr       <= address_a & LINE_MASK;
            r_wdata      <= wdata_b;
            r_op_write   <= 1'b0;
            r_last_grant <= REQ_A;
        end else if (w_grant_b) begin
            r_addr       <= address_b & LINE_MASK;
            r_wdata      <= wdata_b;
            r_op_write   <= write_b;
            r_last_grant <= REQ_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            if ((r_state == GRANT_A) && pmem_resp) begin
                r_rdata_a <= pmem_rdata;
            end
            if ((r_state == GRANT_B) && pmem_resp && !r_op_write) begin
                r_rdata_b <= pmem_rdata;
            end
        end
    end

    // Watchdog saturates at all-ones; the error flag only clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else if (w_grant_a || w_grant_b) begin
            r_wdog <= '0;
        end else if (w_in_grant && !pmem_resp && (r_wdog != WDOG_MAX)) begin
            r_wdog <= w_wdog_inc;
            if (w_wdog_inc == WDOG_MAX) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign rdata_a      = r_rdata_a;
    assign rdata_b      = r_rdata_b;
    assign err_timeout  = r_err;

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Scoreboard bench for cacheline_mem_arbiter: requesters queue expected transactions,
// a pmem model/monitor pops and checks them against round-robin rules.
module tb_cacheline_mem_arbiter;

    localparam int TMO_CYC = 6000;

    typedef struct packed {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } req_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         read_a;
    logic [31:0]  address_a;
    logic [255:0] rdata_a;
    logic         resp_a;
    logic         read_b;
    logic         write_b;
    logic [31:0]  address_b;
    logic [255:0] wdata_b;
    logic [255:0] rdata_b;
    logic         resp_b;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic         err_timeout;

    req_t iss_a[$];
    req_t iss_b[$];
    bit   resp_log[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   fixed_lat = 0;
    bit   hold_resp = 0;
    bit   spur_en = 0;
    int   scnt = 0;

    cacheline_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .read_a(read_a), .address_a(address_a), .rdata_a(rdata_a), .resp_a(resp_a),
        .read_b(read_b), .write_b(write_b), .address_b(address_b), .wdata_b(wdata_b),
        .rdata_b(rdata_b), .resp_b(resp_b),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .err_timeout(err_timeout)
    );

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic issue(input bit port_b, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wd, input bit both);
        req_t it;
        it.wr = wr;
        it.addr = addr;
        it.wdata = wd;
        if (!port_b) begin
            address_a = addr;
            read_a = 1'b1;
            iss_a.push_back(it);
        end else begin
            address_b = addr;
            wdata_b = wd;
            write_b = wr;
            read_b = wr ? both : 1'b1;
            iss_b.push_back(it);
        end
    endtask

    task automatic wait_resp(input bit port_b, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(port_b ? resp_b : resp_a) && cyc < TMO_CYC);
        if (port_b) check_eq("resp_b_arrives", resp_b, 1'b1);
        else        check_eq("resp_a_arrives", resp_a, 1'b1);
        @(posedge clk);
        #1;
        if (port_b) begin
            read_b = 1'b0;
            write_b = 1'b0;
        end else begin
            read_a = 1'b0;
        end
    endtask

    task automatic wait_strobe();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(pmem_read || pmem_write) && c < TMO_CYC);
        check_eq("strobe_arrives", pmem_read | pmem_write, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // pmem model and scoreboard monitor
    initial begin : monitor
        bit   in_txn, last_b, snap_a, snap_b, cur_b, win_b, exp_wr;
        int   lat, pend, iss_sz;
        req_t cur;
        logic [255:0] exp_rd, last_rd_a, last_rd_b;
        in_txn = 0; last_b = 1; snap_a = 0; snap_b = 0; cur_b = 0; exp_wr = 0;
        lat = 1; pend = 0; cur = '0; exp_rd = '0; last_rd_a = '0; last_rd_b = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_txn = 0; last_b = 1; pend = 0; scnt = 0; pmem_resp = 1'b0;
                last_rd_a = '0; last_rd_b = '0;
                iss_a.delete();
                iss_b.delete();
            end else begin
                if (resp_a || resp_b) resp_log.push_back(resp_b);
                if (pend != 0) begin
                    check_eq("resp_a_pulse", resp_a, pend == 1);
                    check_eq("resp_b_pulse", resp_b, pend == 2);
                    if (pend == 1) begin
                        last_rd_a = exp_rd;
                        check_eq("rdata_a", rdata_a, last_rd_a);
                        check_eq("rdata_b_untouched", rdata_b, last_rd_b);
                    end else begin
                        if (!exp_wr) last_rd_b = exp_rd;
                        check_eq("rdata_b", rdata_b, last_rd_b);
                        check_eq("rdata_a_untouched", rdata_a, last_rd_a);
                    end
                    pend = 0;
                end else begin
                    check_eq("no_stray_resp", {resp_a, resp_b}, 2'b00);
                    check_eq("rdata_a_hold", rdata_a, last_rd_a);
                    check_eq("rdata_b_hold", rdata_b, last_rd_b);
                end
                pmem_resp = 1'b0;
                check_eq("strobe_exclusive", pmem_read & pmem_write, 1'b0);
                if (pmem_read || pmem_write) begin
                    if (!in_txn) begin
                        check_eq("grant_has_request", snap_a | snap_b, 1'b1);
                        win_b = (snap_a && snap_b) ? !last_b : snap_b;
                        last_b = win_b;
                        iss_sz = win_b ? iss_b.size() : iss_a.size();
                        check_eq("grant_queue_nonempty", iss_sz != 0, 1'b1);
                        if (iss_sz != 0) begin
                            if (win_b) cur = iss_b.pop_front();
                            else       cur = iss_a.pop_front();
                        end
                        cur_b = win_b;
                        in_txn = 1;
                        scnt = 0;
                        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
                    end
                    check_eq("pmem_address", pmem_address, (cur.addr / 32) * 32);
                    check_eq("pmem_write", pmem_write, cur.wr);
                    check_eq("pmem_read", pmem_read, !cur.wr);
                    if (cur.wr) check_eq("pmem_wdata", pmem_wdata, cur.wdata);
                    scnt++;
                    if (!hold_resp && scnt >= lat) begin
                        exp_rd = rand256();
                        pmem_rdata = exp_rd;
                        pmem_resp = 1'b1;
                        pend = cur_b ? 2 : 1;
                        exp_wr = cur.wr;
                        in_txn = 0;
                    end
                end else if (in_txn) begin
                    check_eq("strobe_held", 1'b0, 1'b1);
                    in_txn = 0;
                end else if (spur_en && $urandom_range(0, 3) == 0) begin
                    pmem_rdata = rand256();
                    pmem_resp = 1'b1;
                end
            end
            snap_a = read_a;
            snap_b = read_b | write_b;
        end
    end

    initial begin : stimulus
        int cyc, c0, c1, base;
        logic [255:0] wd;
        read_a = 0; address_a = '0; read_b = 0; write_b = 0; address_b = '0; wdata_b = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_pmem_read", pmem_read, 1'b0);
        check_eq("rst_pmem_write", pmem_write, 1'b0);
        check_eq("rst_pmem_address", pmem_address, 32'h0);
        check_eq("rst_pmem_wdata", pmem_wdata, 256'h0);
        check_eq("rst_resp", {resp_a, resp_b}, 2'b00);
        check_eq("rst_rdata_a", rdata_a, 256'h0);
        check_eq("rst_rdata_b", rdata_b, 256'h0);
        check_eq("rst_err", err_timeout, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);

        // conflict from reset, then continuous alternation
        base = resp_log.size();
        fork
            for (int i = 0; i < 4; i++) begin issue(0, 0, $urandom, '0, 0); wait_resp(0, c0); end
            for (int i = 0; i < 4; i++) begin issue(1, 0, $urandom, '0, 0); wait_resp(1, c1); end
        join
        check_eq("alt_count", resp_log.size() - base, 8);
        for (int i = 0; i < 8 && base + i < resp_log.size(); i++)
            check_eq("alternation", resp_log[base + i], i % 2);
        idle(2);

        fixed_lat = 3;
        issue(0, 0, 32'h6000_0044, '0, 0);
        wait_resp(0, cyc);
        check_eq("a_alone_latency", cyc, 3 + 2);
        idle(2);

        wd = {16'hDEAD, 224'h0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF_01234567, 16'hBEEF};
        fixed_lat = 2;
        issue(1, 1, 32'h8000_00FF, wd, 0);
        wait_resp(1, cyc);
        check_eq("wb_latency", cyc, 2 + 2);
        idle(2);

        // input churn during GRANT_A
        fixed_lat = 4;
        base = resp_log.size();
        issue(0, 0, 32'h1234_5678, '0, 0);
        wait_strobe();
        idle(1);
        address_a = 32'hFFFF_FFC0;
        issue(1, 0, 32'h4444_4444, '0, 0);
        fork
            wait_resp(0, c0);
            wait_resp(1, c1);
        join
        check_eq("churn_count", resp_log.size() - base, 2);
        if (resp_log.size() - base >= 2) begin
            check_eq("churn_first", resp_log[base], 1'b0);
            check_eq("churn_second", resp_log[base + 1], 1'b1);
        end
        idle(2);

        // random traffic with stray pmem_resp outside GRANT
        fixed_lat = 0;
        spur_en = 1;
        fork
            for (int i = 0; i < 15; i++) begin
                idle($urandom_range(0, 3));
                issue(0, 0, $urandom, '0, 0);
                wait_resp(0, c0);
                check_eq("resp_a_bound", c0 <= 20, 1'b1);
            end
            for (int i = 0; i < 15; i++) begin
                idle($urandom_range(0, 3));
                issue(1, $urandom_range(0, 1), $urandom, rand256(), $urandom_range(0, 1));
                wait_resp(1, c1);
                check_eq("resp_b_bound", c1 <= 20, 1'b1);
            end
        join
        spur_en = 0;
        idle(2);

        // watchdog
        fixed_lat = 1;
        hold_resp = 1;
        issue(0, 0, $urandom, '0, 0);
        cyc = 0;
        do begin @(negedge clk); #1; cyc++; end while (scnt < 4090 && cyc < TMO_CYC);
        check_eq("wdog_quiet", err_timeout, 1'b0);
        do begin @(negedge clk); #1; cyc++; end while (scnt < 4100 && cyc < TMO_CYC);
        check_eq("wdog_fired", err_timeout, 1'b1);
        hold_resp = 0;
        wait_resp(0, cyc);
        idle(3);
        check_eq("err_sticky", err_timeout, 1'b1);

        // asynchronous reset in the middle of a writeback
        hold_resp = 1;
        issue(1, 1, $urandom, rand256(), 0);
        wait_strobe();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_pmem_write", pmem_write, 1'b0);
        check_eq("arst_pmem_read", pmem_read, 1'b0);
        check_eq("arst_pmem_address", pmem_address, 32'h0);
        check_eq("arst_pmem_wdata", pmem_wdata, 256'h0);
        check_eq("arst_err", err_timeout, 1'b0);
        read_b = 0;
        write_b = 0;
        hold_resp = 0;
        repeat (2) begin
            @(negedge clk);
            check_eq("arst_no_resp", {resp_a, resp_b}, 2'b00);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);
        base = resp_log.size();
        fork
            begin issue(0, 0, $urandom, '0, 0); wait_resp(0, c0); end
            begin issue(1, 0, $urandom, '0, 0); wait_resp(1, c1); end
        join
        check_eq("post_rst_count", resp_log.size() - base, 2);
        if (resp_log.size() - base >= 2) begin
            check_eq("post_rst_first", resp_log[base], 1'b0);
            check_eq("post_rst_second", resp_log[base + 1], 1'b1);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
